ustc_rn: RTL and testbench



---
 rtl/ustc_pkg.sv | 36 +++
 rtl/ustc_reduce_xbar.sv | 33 +++
 rtl/ustc_rn.sv | 147 ++++++++++++++
 tb/tb_ustc_rn.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ustc_pkg.sv
// Shared definitions for the sparse-network reduction path: FSM encoding,
// width helpers and the default geometry of the network.
package ustc_pkg;

    // Controller states of the reduction network.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    // Default network geometry.
    localparam int DEF_NUM_XBAR  = 4;
    localparam int DEF_N_XBAR_IN = 8;
    localparam int DEF_DW_DATA   = 32;
    localparam int DEF_DW_IDX    = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int ustc_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter width able to address n items; never narrower than one bit.
    function automatic int ustc_cnt_width(input int n);
        return (n > 1) ? ustc_clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ustc_reduce_xbar.sv
// Combinational masked scatter-add: N lanes, each tagged with a bin index,
// are summed into N bins. Lanes whose index does not name a valid bin never
// match any bin and therefore vanish. Sums wrap at DW bits.
module ustc_reduce_xbar
    import ustc_pkg::*;
#(
    parameter int N  = DEF_N_XBAR_IN,
    parameter int DW = DEF_DW_DATA,
    parameter int IW = DEF_DW_IDX
) (
    input  logic [N*DW-1:0] lane_data_i,
    input  logic [N*IW-1:0] lane_idx_i,
    input  logic [N-1:0]    lane_mask_i,
    output logic [N*DW-1:0] bin_sum_o
);

    for (genvar gi = 0; gi < N; gi++) begin : g_bin
        logic [DW-1:0] sum;

        // Sum every enabled lane that targets bin gi.
        always_comb begin
            sum = '0;
            for (int k = 0; k < N; k++) begin
                if (lane_mask_i[k] && (lane_idx_i[k*IW +: IW] == IW'(gi))) begin
                    sum = sum + lane_data_i[k*DW +: DW];
                end
            end
        end

        assign bin_sum_o[gi*DW +: DW] = sum;
    end

endmodule

// File: rtl/ustc_rn.sv
// Reduction/collection network: captures one bundle of lane results, walks
// the lane groups one per cycle through a shared scatter-add, and presents
// the accumulated bins to writeback with a valid/ready handshake.
module ustc_rn
    import ustc_pkg::*;
#(
    parameter int NUM_XBAR  = DEF_NUM_XBAR,
    parameter int N_XBAR_IN = DEF_N_XBAR_IN,
    parameter int N_DN_IN   = NUM_XBAR * N_XBAR_IN,
    parameter int DW_DATA   = DEF_DW_DATA,
    parameter int DW_IDX    = DEF_DW_IDX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_DN_IN*DW_DATA-1:0]   in,
    input  logic [N_DN_IN*DW_IDX-1:0]    idx,
    input  logic [N_DN_IN-1:0]           mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_XBAR_IN*DW_DATA-1:0] out
);

    localparam int GW      = ustc_cnt_width(NUM_XBAR);
    localparam int GRP_DW  = N_XBAR_IN * DW_DATA;
    localparam int GRP_IW  = N_XBAR_IN * DW_IDX;
    localparam int ACC_W   = N_XBAR_IN * DW_DATA;

    state_e                      state_q, state_d;
    logic [GW-1:0]               g_q, g_d;
    logic [N_DN_IN*DW_DATA-1:0]  in_q;
    logic [N_DN_IN*DW_IDX-1:0]   idx_q;
    logic [N_DN_IN-1:0]          mask_q;
    logic [ACC_W-1:0]            acc_q, acc_d;

    logic                        capture;
    logic                        accum_en;

    // Group mux: slice the captured bundle into per-crossbar lane groups.
    logic [GRP_DW-1:0]    grp_data_arr [NUM_XBAR];
    logic [GRP_IW-1:0]    grp_idx_arr  [NUM_XBAR];
    logic [N_XBAR_IN-1:0] grp_mask_arr [NUM_XBAR];

    for (genvar gi = 0; gi < NUM_XBAR; gi++) begin : g_grp
        assign grp_data_arr[gi] = in_q[gi*GRP_DW +: GRP_DW];
        assign grp_idx_arr[gi]  = idx_q[gi*GRP_IW +: GRP_IW];
        assign grp_mask_arr[gi] = mask_q[gi*N_XBAR_IN +: N_XBAR_IN];
    end

    logic [GRP_DW-1:0]    grp_data;
    logic [GRP_IW-1:0]    grp_idx;
    logic [N_XBAR_IN-1:0] grp_mask;
    logic [ACC_W-1:0]     part_sum;

    assign grp_data = grp_data_arr[g_q];
    assign grp_idx  = grp_idx_arr[g_q];
    assign grp_mask = grp_mask_arr[g_q];

    ustc_reduce_xbar #(
        .N  (N_XBAR_IN),
        .DW (DW_DATA),
        .IW (DW_IDX)
    ) u_reduce (
        .lane_data_i (grp_data),
        .lane_idx_i  (grp_idx),
        .lane_mask_i (grp_mask),
        .bin_sum_o   (part_sum)
    );

    // Next-state, group counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        capture   = 1'b0;
        accum_en  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    g_d     = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                accum_en = 1'b1;
                if (g_q == GW'(NUM_XBAR - 1)) begin
                    g_d     = '0;
                    state_d = ST_OUT;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                g_d     = '0;
            end
        endcase
    end

    // Accumulator update: cleared on capture, one group folded in per ACCUM cycle.
    always_comb begin
        acc_d = acc_q;
        if (capture) begin
            acc_d = '0;
        end else if (accum_en) begin
            for (int j = 0; j < N_XBAR_IN; j++) begin
                acc_d[j*DW_DATA +: DW_DATA] = acc_q[j*DW_DATA +: DW_DATA]
                                            + part_sum[j*DW_DATA +: DW_DATA];
            end
        end
    end

    // State, counter, accumulators and captured bundle registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            acc_q   <= '0;
            in_q    <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            acc_q   <= acc_d;
            if (capture) begin
                in_q   <= in;
                idx_q  <= idx;
                mask_q <= mask;
            end
        end
    end

    // Accumulators are registers, so the result stays stable while OUT waits.
    assign out = acc_q;

endmodule

// File: tb/tb_ustc_rn.sv
// Directed testbench for ustc_rn: reset, identity reduction, collisions,
// masking/out-of-range indices, backpressure, wraparound and mid-run reset.
module tb_ustc_rn;

    localparam int NUM_XBAR  = 4;
    localparam int N_XBAR_IN = 8;
    localparam int N_DN_IN   = NUM_XBAR * N_XBAR_IN;
    localparam int DW_DATA   = 32;
    localparam int DW_IDX    = 4;

    logic                         clk = 1'b0;
    logic                         reset = 1'b0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [N_DN_IN*DW_DATA-1:0]   in_data = '0;
    logic [N_DN_IN*DW_IDX-1:0]    idx_data = '0;
    logic [N_DN_IN-1:0]           mask_data = '0;
    logic                         out_valid;
    logic                         out_ready = 1'b0;
    logic [N_XBAR_IN*DW_DATA-1:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ustc_rn #(
        .NUM_XBAR  (NUM_XBAR),
        .N_XBAR_IN (N_XBAR_IN),
        .N_DN_IN   (N_DN_IN),
        .DW_DATA   (DW_DATA),
        .DW_IDX    (DW_IDX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .idx       (idx_data),
        .mask      (mask_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data)
    );

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic load_identity();
        for (int k = 0; k < N_DN_IN; k++) begin
            in_data[k*DW_DATA +: DW_DATA] = 32'(k + 1);
            idx_data[k*DW_IDX +: DW_IDX]  = 4'(k % 8);
        end
        mask_data = '1;
    endtask

    task automatic load_collision();
        for (int k = 0; k < N_DN_IN; k++) begin
            in_data[k*DW_DATA +: DW_DATA] = 32'd1;
            idx_data[k*DW_IDX +: DW_IDX]  = 4'd3;
        end
        mask_data = '1;
    endtask

    // Present in_valid for one edge; caller is 1 time unit after an edge in IDLE.
    task automatic send();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("send: bundle presented, in_ready after edge=%0b", in_ready);
    endtask

    // Count edges until out_valid is seen; -1 if the budget expires.
    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%0b in_ready=%0b out=%h required 0/1/0",
                     out_valid, in_ready, out_data);
        end else $display("reset_hold: ok");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%0b in_ready=%0b out=%h required 0/1/0",
                     out_valid, in_ready, out_data);
        end else $display("reset_idle: ok");
    endtask

    task automatic test_identity();
        logic [31:0] exp;
        int          seen;
        load_identity();
        send();
        // Result becomes visible four edges after the capture edge.
        seen = -1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL identity_busy%0d: in_ready=%0b out_valid=%0b required 0/0",
                         i, in_ready, out_valid);
            end
            @(posedge clk); #1;
            if (out_valid && seen < 0) seen = i;
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL identity_latency: out_valid at edge %0d required 4", seen);
        end else $display("identity_latency: out_valid at edge %0d", seen);
        // Scramble inputs: captured copy must be used.
        in_data = '1;
        mask_data = '0;
        for (int j = 0; j < N_XBAR_IN; j++) begin
            exp = 32'(4 * j + 52);
            checks++;
            if (out_data[j*DW_DATA +: DW_DATA] !== exp) begin
                errors++;
                $display("FAIL identity_bin%0d: got %h required %h",
                         j, out_data[j*DW_DATA +: DW_DATA], exp);
            end else $display("identity_bin%0d: %0d", j, out_data[j*DW_DATA +: DW_DATA]);
        end
        accept();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL identity_accept: in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_collision();
        int cyc;
        logic [31:0] exp;
        load_collision();
        send();
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL collision_latency: edge %0d required 4", cyc);
        end
        for (int j = 0; j < N_XBAR_IN; j++) begin
            exp = (j == 3) ? 32'd32 : 32'd0;
            checks++;
            if (out_data[j*DW_DATA +: DW_DATA] !== exp) begin
                errors++;
                $display("FAIL collision_bin%0d: got %h required %h",
                         j, out_data[j*DW_DATA +: DW_DATA], exp);
            end
        end
        $display("collision: out=%h", out_data);
        accept();
    endtask

    task automatic test_mask_range();
        int cyc;
        logic [31:0] exp;
        for (int k = 0; k < N_DN_IN; k++) begin
            in_data[k*DW_DATA +: DW_DATA] = 32'd100;
            idx_data[k*DW_IDX +: DW_IDX]  = 4'(k % 8);
        end
        mask_data = '0;
        in_data[0 +: DW_DATA]          = 32'd5;
        idx_data[0 +: DW_IDX]          = 4'd2;
        in_data[DW_DATA +: DW_DATA]    = 32'd7;
        idx_data[DW_IDX +: DW_IDX]     = 4'd9;
        mask_data[1:0]                 = 2'b11;
        send();
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL mask_latency: edge %0d required 4", cyc);
        end
        for (int j = 0; j < N_XBAR_IN; j++) begin
            exp = (j == 2) ? 32'd5 : 32'd0;
            checks++;
            if (out_data[j*DW_DATA +: DW_DATA] !== exp) begin
                errors++;
                $display("FAIL mask_bin%0d: got %h required %h",
                         j, out_data[j*DW_DATA +: DW_DATA], exp);
            end
        end
        $display("mask_range: out=%h", out_data);
        accept();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [N_XBAR_IN*DW_DATA-1:0] exp_vec;
        for (int j = 0; j < N_XBAR_IN; j++) exp_vec[j*DW_DATA +: DW_DATA] = 32'(4 * j + 52);
        load_identity();
        send();
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL bp_latency: edge %0d required 4", cyc);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = {N_DN_IN{32'hA5A5_0000 | 32'(i)}};
            mask_data = '1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_vec) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b out=%h required 1/0/%h",
                         i, out_valid, in_ready, out_data, exp_vec);
            end
        end
        in_valid = 1'b0;
        $display("backpressure: held 10 cycles");
        accept();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [31:0] exp;
        in_data   = '0;
        idx_data  = '0;
        mask_data = '0;
        in_data[0 +: DW_DATA]       = 32'hFFFF_FFFF;
        in_data[DW_DATA +: DW_DATA] = 32'hFFFF_FFFF;
        mask_data[1:0]              = 2'b11;
        send();
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL wrap_latency: edge %0d required 4", cyc);
        end
        for (int j = 0; j < N_XBAR_IN; j++) begin
            exp = (j == 0) ? 32'hFFFF_FFFE : 32'd0;
            checks++;
            if (out_data[j*DW_DATA +: DW_DATA] !== exp) begin
                errors++;
                $display("FAIL wrap_bin%0d: got %h required %h",
                         j, out_data[j*DW_DATA +: DW_DATA], exp);
            end
        end
        $display("wrap: bin0=%h", out_data[0 +: DW_DATA]);
        accept();
    endtask

    task automatic test_reset_mid_accum();
        int cyc;
        logic [31:0] exp;
        load_identity();
        send();
        @(posedge clk); #1;   // first ACCUM edge done; now in the second ACCUM cycle
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%0b out_valid=%0b out=%h required 1/0/0",
                     in_ready, out_valid, out_data);
        end else $display("midreset: aborted to IDLE");
        load_collision();
        send();
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL midreset_latency: edge %0d required 4", cyc);
        end
        for (int j = 0; j < N_XBAR_IN; j++) begin
            exp = (j == 3) ? 32'd32 : 32'd0;
            checks++;
            if (out_data[j*DW_DATA +: DW_DATA] !== exp) begin
                errors++;
                $display("FAIL midreset_bin%0d: got %h required %h",
                         j, out_data[j*DW_DATA +: DW_DATA], exp);
            end
        end
        $display("midreset_followup: out=%h", out_data);
        accept();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_collision();
        test_mask_range();
        test_backpressure();
        test_wrap();
        test_reset_mid_accum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
